// File: rtl/idex_hazard_ctrl_if.sv
// Signal bundle between the ID/EX hazard controller and the pipeline datapath.
// The datapath is the master: it presents the ID and ID/EX instruction fields
// and consumes the latch enable, flush and bubble controls.
interface idex_hazard_ctrl_if;
    logic [3:0]  id_rs;
    logic [3:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_is_halt;
    logic [3:0]  idex_wreg;
    logic        idex_memread;
    logic        idex_regwrite;
    logic        ex_branch_taken;
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_en;
    logic        idex_bubble;
    logic        halted;
    logic [15:0] stall_count;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_halt,
        output idex_wreg, idex_memread, idex_regwrite, ex_branch_taken,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, halted, stall_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_halt,
        input  idex_wreg, idex_memread, idex_regwrite, ex_branch_taken,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, halted, stall_count
    );
endinterface

// File: rtl/idex_hazard_ctrl.sv
// ID/EX hazard controller: load-use stalls, taken-branch flushes, HLT drain/stop
// and a saturating stall-cycle counter for the 16-bit pipelined CPU.
module idex_hazard_ctrl #(
    parameter int STALL_CYCLES = 1,
    parameter int HALT_DRAIN   = 3
) (
    input  logic             clk,
    input  logic             rst,
    idex_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam bit       MULTI_STALL   = (STALL_CYCLES > 32'sd1);
    localparam logic [2:0] STALL_SUB_INIT = 3'(STALL_CYCLES - 32'sd1);
    localparam logic [2:0] DRAIN_SUB_INIT = 3'(HALT_DRAIN);

    state_t      state_r;
    logic [2:0]  sub_r;
    logic        halted_r;
    logic [15:0] stall_count_r;

    logic haz_s;
    logic pc_en_s;
    logic ifid_en_s;
    logic ifid_flush_s;
    logic idex_en_s;
    logic idex_bubble_s;

    // Load-use check; register 0 is hard-wired and can never be the hazard source.
    function automatic logic load_use_hit(
        input logic [3:0] rs,
        input logic [3:0] rt,
        input logic       uses_rs,
        input logic       uses_rt,
        input logic [3:0] wreg,
        input logic       memread,
        input logic       regwrite
    );
        logic producer;
        producer = memread & regwrite & (wreg != 4'd0);
        return producer & ((uses_rs & (rs == wreg)) | (uses_rt & (rt == wreg)));
    endfunction

    // Hazard detection between the ID instruction and the load held in ID/EX.
    always_comb begin
        haz_s = load_use_hit(bus.id_rs, bus.id_rt, bus.id_uses_rs, bus.id_uses_rt,
                             bus.idex_wreg, bus.idex_memread, bus.idex_regwrite);
    end

    // Mealy latch controls from the registered state and the current inputs.
    always_comb begin
        pc_en_s       = 1'b0;
        ifid_en_s     = 1'b0;
        ifid_flush_s  = 1'b0;
        idex_en_s     = 1'b0;
        idex_bubble_s = 1'b0;
        if (!rst) begin
            ifid_flush_s  = 1'b1;
            idex_bubble_s = 1'b1;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (bus.ex_branch_taken) begin
                        pc_en_s       = 1'b1;
                        ifid_en_s     = 1'b1;
                        ifid_flush_s  = 1'b1;
                        idex_en_s     = 1'b1;
                        idex_bubble_s = 1'b1;
                    end else if (haz_s) begin
                        idex_en_s     = 1'b1;
                        idex_bubble_s = 1'b1;
                    end else if (bus.id_is_halt) begin
                        // HLT itself still advances into ID/EX; only fetch stops.
                        ifid_en_s     = 1'b1;
                        idex_en_s     = 1'b1;
                    end else begin
                        pc_en_s       = 1'b1;
                        ifid_en_s     = 1'b1;
                        idex_en_s     = 1'b1;
                    end
                end
                ST_STALL, ST_DRAIN: begin
                    if (bus.ex_branch_taken) begin
                        pc_en_s       = 1'b1;
                        ifid_en_s     = 1'b1;
                        ifid_flush_s  = 1'b1;
                        idex_en_s     = 1'b1;
                        idex_bubble_s = 1'b1;
                    end else begin
                        idex_en_s     = 1'b1;
                        idex_bubble_s = 1'b1;
                    end
                end
                ST_HALTED: begin
                    pc_en_s       = 1'b0;
                    idex_en_s     = 1'b0;
                end
                default: begin
                    ifid_flush_s  = 1'b1;
                    idex_bubble_s = 1'b1;
                end
            endcase
        end
    end

    // Control FSM: state, bubble/drain sub-counter and the halted flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_RUN;
            sub_r    <= 3'd0;
            halted_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (bus.ex_branch_taken) begin
                        state_r <= ST_RUN;
                        sub_r   <= 3'd0;
                    end else if (haz_s) begin
                        if (MULTI_STALL) begin
                            state_r <= ST_STALL;
                            sub_r   <= STALL_SUB_INIT;
                        end else begin
                            state_r <= ST_RUN;
                            sub_r   <= 3'd0;
                        end
                    end else if (bus.id_is_halt) begin
                        state_r <= ST_DRAIN;
                        sub_r   <= DRAIN_SUB_INIT;
                    end else begin
                        state_r <= ST_RUN;
                        sub_r   <= 3'd0;
                    end
                end
                ST_STALL: begin
                    if (bus.ex_branch_taken || (sub_r <= 3'd1)) begin
                        state_r <= ST_RUN;
                        sub_r   <= 3'd0;
                    end else begin
                        sub_r   <= sub_r - 3'd1;
                    end
                end
                ST_DRAIN: begin
                    // A taken branch means the HLT was on the wrong path.
                    if (bus.ex_branch_taken) begin
                        state_r <= ST_RUN;
                        sub_r   <= 3'd0;
                    end else if (sub_r <= 3'd1) begin
                        state_r  <= ST_HALTED;
                        sub_r    <= 3'd0;
                        halted_r <= 1'b1;
                    end else begin
                        sub_r    <= sub_r - 3'd1;
                    end
                end
                ST_HALTED: begin
                    state_r  <= ST_HALTED;
                    halted_r <= 1'b1;
                end
                default: begin
                    state_r  <= ST_RUN;
                    sub_r    <= 3'd0;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of fetch-stalled cycles while the core is still live.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count_r <= 16'd0;
        end else if (!pc_en_s && (state_r != ST_HALTED) && (stall_count_r != 16'hFFFF)) begin
            stall_count_r <= stall_count_r + 16'd1;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign bus.pc_en       = pc_en_s;
    assign bus.ifid_en     = ifid_en_s;
    assign bus.ifid_flush  = ifid_flush_s;
    assign bus.idex_en     = idex_en_s;
    assign bus.idex_bubble = idex_bubble_s;
    assign bus.halted      = halted_r;
    assign bus.stall_count = stall_count_r;

endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// Directed bench for idex_hazard_ctrl: a vector table on a STALL_CYCLES=1 core
// plus hand-written multi-cycle sequences on a STALL_CYCLES=3 core.
module tb_idex_hazard_ctrl;

    typedef struct packed {
        logic [3:0] rs;
        logic [3:0] rt;
        logic       urs;
        logic       urt;
        logic       halt;
        logic [3:0] wreg;
        logic       mr;
        logic       rw;
        logic       br;
    } in_t;

    typedef struct {
        in_t        in;
        logic [5:0] exp;
    } vec_t;

    // Output pack order: {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, halted}
    localparam logic [5:0] O_RUN   = 6'b110100;
    localparam logic [5:0] O_HAZ   = 6'b000110;
    localparam logic [5:0] O_BR    = 6'b111110;
    localparam logic [5:0] O_HLT   = 6'b010100;
    localparam logic [5:0] O_WAIT  = 6'b000110;
    localparam logic [5:0] O_STOP  = 6'b000001;
    localparam logic [5:0] O_RESET = 6'b001010;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   exp_cnt_a;

    idex_hazard_ctrl_if bus_a ();
    idex_hazard_ctrl_if bus_b ();

    idex_hazard_ctrl #(.STALL_CYCLES(1), .HALT_DRAIN(3)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    idex_hazard_ctrl #(.STALL_CYCLES(3), .HALT_DRAIN(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    logic [5:0] out_a;
    logic [5:0] out_b;
    assign out_a = {bus_a.pc_en, bus_a.ifid_en, bus_a.ifid_flush, bus_a.idex_en, bus_a.idex_bubble, bus_a.halted};
    assign out_b = {bus_b.pc_en, bus_b.ifid_en, bus_b.ifid_flush, bus_b.idex_en, bus_b.idex_bubble, bus_b.halted};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic in_t mk(input logic [3:0] rs, input logic [3:0] rt,
                               input logic urs, input logic urt, input logic halt,
                               input logic [3:0] wreg, input logic mr, input logic rw,
                               input logic br);
        in_t v;
        v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.halt = halt;
        v.wreg = wreg; v.mr = mr; v.rw = rw; v.br = br;
        return v;
    endfunction

    task automatic drive_a(input in_t v);
        bus_a.id_rs = v.rs; bus_a.id_rt = v.rt;
        bus_a.id_uses_rs = v.urs; bus_a.id_uses_rt = v.urt; bus_a.id_is_halt = v.halt;
        bus_a.idex_wreg = v.wreg; bus_a.idex_memread = v.mr; bus_a.idex_regwrite = v.rw;
        bus_a.ex_branch_taken = v.br;
    endtask

    task automatic drive_b(input in_t v);
        bus_b.id_rs = v.rs; bus_b.id_rt = v.rt;
        bus_b.id_uses_rs = v.urs; bus_b.id_uses_rt = v.urt; bus_b.id_is_halt = v.halt;
        bus_b.idex_wreg = v.wreg; bus_b.idex_memread = v.mr; bus_b.idex_regwrite = v.rw;
        bus_b.ex_branch_taken = v.br;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    in_t  idle_v;
    in_t  lu_v;
    in_t  lu_br_v;
    in_t  br_v;
    in_t  halt_v;
    in_t  all_v;
    vec_t vecs[$];

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        exp_cnt_a = 0;
        idle_v  = mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        lu_v    = mk(4'd3, 4'd5, 1'b1, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0);
        lu_br_v = mk(4'd3, 4'd5, 1'b1, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 1'b1);
        br_v    = mk(4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        halt_v  = mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        all_v   = mk(4'd3, 4'd3, 1'b1, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1);

        // Vector table for the single-bubble core (state never leaves RUN here).
        vecs.push_back('{idle_v, O_RUN});
        for (int k = 0; k < 10; k++) begin
            vecs.push_back('{mk(4'(k + 1), 4'(k + 2), 1'b1, 1'b1, 1'b0, 4'(k + 1), 1'b0, 1'b1, 1'b0), O_RUN});
        end
        vecs.push_back('{mk(4'd3, 4'd7, 1'b1, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0), O_HAZ});
        vecs.push_back('{mk(4'd5, 4'd3, 1'b0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0), O_HAZ});
        vecs.push_back('{mk(4'd3, 4'd3, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0), O_RUN});
        vecs.push_back('{mk(4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0), O_RUN});
        vecs.push_back('{mk(4'd3, 4'd3, 1'b1, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0), O_RUN});
        vecs.push_back('{mk(4'd3, 4'd3, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0), O_RUN});
        vecs.push_back('{mk(4'd3, 4'd3, 1'b1, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 1'b1), O_BR});
        vecs.push_back('{br_v, O_BR});
        vecs.push_back('{mk(4'd1, 4'd15, 1'b1, 1'b1, 1'b0, 4'd15, 1'b1, 1'b1, 1'b0), O_HAZ});
        vecs.push_back('{mk(4'd4, 4'd5, 1'b1, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0), O_RUN});
        vecs.push_back('{mk(4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0), O_HAZ});
        vecs.push_back('{idle_v, O_RUN});

        rst = 1'b0;
        drive_a(idle_v);
        drive_b(idle_v);
        #2;
        check("reset_out_a", 32'(out_a), 32'(O_RESET));
        check("reset_out_b", 32'(out_b), 32'(O_RESET));
        check("reset_cnt_a", 32'(bus_a.stall_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive_a(vecs[i].in);
            #2;
            check($sformatf("vec%0d_out", i), 32'(out_a), 32'(vecs[i].exp));
            check($sformatf("vec%0d_cnt", i), 32'(bus_a.stall_count), 32'(exp_cnt_a));
            if (!vecs[i].exp[5]) exp_cnt_a++;
        end
        @(negedge clk);
        drive_a(idle_v);
        #2;
        check("table_cnt_a", 32'(bus_a.stall_count), 32'(exp_cnt_a));
        check("idle_cnt_b", 32'(bus_b.stall_count), 32'd0);

        // Three-bubble load-use on the STALL_CYCLES=3 core.
        @(negedge clk); drive_b(lu_v); #2;
        check("b_lu_haz", 32'(out_b), 32'(O_HAZ));
        @(negedge clk); drive_b(idle_v); #2;
        check("b_stall1", 32'(out_b), 32'(O_WAIT));
        @(negedge clk); #2;
        check("b_stall2", 32'(out_b), 32'(O_WAIT));
        @(negedge clk); #2;
        check("b_resume", 32'(out_b), 32'(O_RUN));
        check("b_cnt3", 32'(bus_b.stall_count), 32'd3);

        // Load-use coinciding with a taken branch: flush wins, no stall entered.
        @(negedge clk); drive_b(lu_br_v); #2;
        check("b_lu_br", 32'(out_b), 32'(O_BR));
        @(negedge clk); drive_b(idle_v); #2;
        check("b_after_lu_br", 32'(out_b), 32'(O_RUN));
        check("b_cnt_lu_br", 32'(bus_b.stall_count), 32'd3);

        // Taken branch arriving while already in STALL.
        @(negedge clk); drive_b(lu_v); #2;
        check("b_lu2_haz", 32'(out_b), 32'(O_HAZ));
        @(negedge clk); drive_b(br_v); #2;
        check("b_stall_br", 32'(out_b), 32'(O_BR));
        @(negedge clk); drive_b(idle_v); #2;
        check("b_after_stall_br", 32'(out_b), 32'(O_RUN));
        check("b_cnt4", 32'(bus_b.stall_count), 32'd4);

        // HLT in the shadow of a taken branch: drain aborted, never halts.
        @(negedge clk); drive_b(halt_v); #2;
        check("b_hlt", 32'(out_b), 32'(O_HLT));
        @(negedge clk); drive_b(idle_v); #2;
        check("b_drain1", 32'(out_b), 32'(O_WAIT));
        @(negedge clk); drive_b(br_v); #2;
        check("b_drain_br", 32'(out_b), 32'(O_BR));
        @(negedge clk); drive_b(idle_v); #2;
        check("b_after_drain_br", 32'(out_b), 32'(O_RUN));
        repeat (4) @(negedge clk);
        #2;
        check("b_not_halted", 32'(out_b), 32'(O_RUN));
        check("b_cnt6", 32'(bus_b.stall_count), 32'd6);

        // HLT with HALT_DRAIN=3: halted after the fourth edge, four stall cycles counted.
        @(negedge clk); drive_a(halt_v); #2;
        check("a_hlt", 32'(out_a), 32'(O_HLT));
        @(negedge clk); drive_a(idle_v); #2;
        check("a_drain1", 32'(out_a), 32'(O_WAIT));
        @(negedge clk); #2;
        check("a_drain2", 32'(out_a), 32'(O_WAIT));
        @(negedge clk); #2;
        check("a_drain3", 32'(out_a), 32'(O_WAIT));
        @(negedge clk); #2;
        check("a_halted", 32'(out_a), 32'(O_STOP));
        check("a_cnt_halt", 32'(bus_a.stall_count), 32'(exp_cnt_a + 4));
        @(negedge clk); drive_a(all_v); #2;
        check("a_halted_ignores", 32'(out_a), 32'(O_STOP));
        @(negedge clk); drive_b(lu_v); #2;
        check("a_cnt_frozen", 32'(bus_a.stall_count), 32'(exp_cnt_a + 4));
        @(negedge clk); drive_b(idle_v); #2;
        check("b_stall_prereset", 32'(out_b), 32'(O_WAIT));

        // Asynchronous reset from HALTED (core A) and mid-STALL (core B).
        rst = 1'b0;
        #1;
        check("a_rst_out", 32'(out_a), 32'(O_RESET));
        check("a_rst_cnt", 32'(bus_a.stall_count), 32'd0);
        check("b_rst_out", 32'(out_b), 32'(O_RESET));
        check("b_rst_cnt", 32'(bus_b.stall_count), 32'd0);
        @(negedge clk);
        drive_a(idle_v);
        rst = 1'b1;
        @(negedge clk); #2;
        check("a_run_post_rst", 32'(out_a), 32'(O_RUN));
        check("b_run_post_rst", 32'(out_b), 32'(O_RUN));
        check("a_cnt_post_rst", 32'(bus_a.stall_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
